// File: rtl/vga_line_fetch_arbiter.sv
// vga_line_fetch_arbiter
//   Shares one memory command port between display line prefetch (burst
//   reads) and the drawing engine (single-word writes). A line request
//   starts a sequence of LINE_PIXELS/BURST_LEN read bursts. A pending write
//   may slip in between any two bursts, but never more than one write.
//
// Ports
//   vga_clk, rst_n        clock, async active-low reset
//   Line_Req_Sig/Num_Sig  one-cycle line prefetch request + row index
//   Wr_Req/Addr/Data      drawing-engine write, level held until Wr_Ack
//   Wr_Ack                write command accepted (same cycle as transfer)
//   Mem_Cmd_*             valid/ready command port (Wr, Addr, Len, data)
//   Line_Busy/Line_Done   fetch in progress / last burst accepted
//   Underrun              sticky: line request while a line was busy
module vga_line_fetch_arbiter #(
  parameter int LINE_PIXELS = 1920,
  parameter int BURST_LEN   = 16,
  parameter int ADDR_W      = 22
) (
  input  logic              vga_clk,
  input  logic              rst_n,
  input  logic              Line_Req_Sig,
  input  logic [11:0]       Line_Num_Sig,
  input  logic              Wr_Req,
  input  logic [ADDR_W-1:0] Wr_Addr,
  input  logic [15:0]       Wr_Data,
  output logic              Wr_Ack,
  output logic              Mem_Cmd_Valid,
  input  logic              Mem_Cmd_Ready,
  output logic              Mem_Cmd_Wr,
  output logic [ADDR_W-1:0] Mem_Cmd_Addr,
  output logic [7:0]        Mem_Cmd_Len,
  output logic [15:0]       Mem_Wr_Data,
  output logic              Line_Busy,
  output logic              Line_Done,
  output logic              Underrun
);

  localparam int BURSTS = LINE_PIXELS / BURST_LEN;
  localparam int BIW    = (BURSTS > 1) ? $clog2(BURSTS) : 1;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] RD_ISSUE = 2'd1;
  localparam logic [1:0] WR_ISSUE = 2'd2;

  logic [1:0]        state, state_nxt;
  logic              line_busy, line_done_q, underrun_q;
  logic [BIW-1:0]    burst_idx;
  logic [ADDR_W-1:0] rd_addr;
  logic              line_accept, last_burst, rd_xfer, wr_xfer, cmd_valid;

  assign line_accept = Line_Req_Sig & ~line_busy;
  assign last_burst  = (burst_idx == BIW'(BURSTS - 1));

  // When the last burst is followed straight by a write, the write is held
  // off for the Line_Done cycle so Wr_Ack and Line_Done never coincide.
  // Valid has not been raised yet in that cycle, so nothing is withdrawn.
  assign cmd_valid = (state == RD_ISSUE) | ((state == WR_ISSUE) & ~line_done_q);
  assign rd_xfer   = (state == RD_ISSUE) & Mem_Cmd_Ready;
  assign wr_xfer   = (state == WR_ISSUE) & ~line_done_q & Mem_Cmd_Ready;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        // A request arriving this cycle counts as pending, so it beats a write.
        if (line_busy | line_accept) state_nxt = RD_ISSUE;
        else if (Wr_Req)             state_nxt = WR_ISSUE;
      end
      RD_ISSUE: begin
        if (rd_xfer) begin
          if (Wr_Req)          state_nxt = WR_ISSUE;
          else if (last_burst) state_nxt = IDLE;
          else                 state_nxt = RD_ISSUE;
        end
      end
      WR_ISSUE: begin
        if (wr_xfer) state_nxt = (line_busy | line_accept) ? RD_ISSUE : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      line_busy   <= 1'b0;
      line_done_q <= 1'b0;
      underrun_q  <= 1'b0;
      burst_idx   <= '0;
      rd_addr     <= '0;
    end else begin
      state       <= state_nxt;
      line_done_q <= rd_xfer & last_burst;
      if (Line_Req_Sig & line_busy) underrun_q <= 1'b1;

      if (line_accept) begin
        line_busy <= 1'b1;
        burst_idx <= '0;
        // Line base is computed once; bursts then step by BURST_LEN,
        // all arithmetic wrapping at ADDR_W bits.
        rd_addr   <= ADDR_W'(Line_Num_Sig) * ADDR_W'(LINE_PIXELS);
      end else if (rd_xfer) begin
        rd_addr <= rd_addr + ADDR_W'(BURST_LEN);
        if (last_burst) begin
          line_busy <= 1'b0;
          burst_idx <= '0;
        end else begin
          burst_idx <= burst_idx + 1'b1;
        end
      end
    end
  end

  assign Mem_Cmd_Valid = cmd_valid;
  assign Mem_Cmd_Wr    = (state == WR_ISSUE);
  assign Mem_Cmd_Addr  = (state == RD_ISSUE) ? rd_addr :
                         (state == WR_ISSUE) ? Wr_Addr : '0;
  assign Mem_Cmd_Len   = (state == RD_ISSUE) ? 8'(BURST_LEN) :
                         (state == WR_ISSUE) ? 8'd1 : 8'd0;
  assign Mem_Wr_Data   = (state == WR_ISSUE) ? Wr_Data : 16'd0;
  assign Wr_Ack        = wr_xfer & Wr_Req;
  assign Line_Busy     = line_busy;
  assign Line_Done     = line_done_q;
  assign Underrun      = underrun_q;

endmodule

// File: tb/tb_vga_line_fetch_arbiter.sv
module tb_vga_line_fetch_arbiter;
  localparam int LP = 1920;
  localparam int BL = 16;
  localparam int AW = 22;
  localparam int NB = LP / BL;

  logic          vga_clk, rst_n;
  logic          Line_Req_Sig;
  logic [11:0]   Line_Num_Sig;
  logic          Wr_Req;
  logic [AW-1:0] Wr_Addr;
  logic [15:0]   Wr_Data;
  logic          Wr_Ack, Mem_Cmd_Valid, Mem_Cmd_Ready, Mem_Cmd_Wr;
  logic [AW-1:0] Mem_Cmd_Addr;
  logic [7:0]    Mem_Cmd_Len;
  logic [15:0]   Mem_Wr_Data;
  logic          Line_Busy, Line_Done, Underrun;

  vga_line_fetch_arbiter #(.LINE_PIXELS(LP), .BURST_LEN(BL), .ADDR_W(AW)) dut (
    .vga_clk(vga_clk), .rst_n(rst_n),
    .Line_Req_Sig(Line_Req_Sig), .Line_Num_Sig(Line_Num_Sig),
    .Wr_Req(Wr_Req), .Wr_Addr(Wr_Addr), .Wr_Data(Wr_Data), .Wr_Ack(Wr_Ack),
    .Mem_Cmd_Valid(Mem_Cmd_Valid), .Mem_Cmd_Ready(Mem_Cmd_Ready),
    .Mem_Cmd_Wr(Mem_Cmd_Wr), .Mem_Cmd_Addr(Mem_Cmd_Addr), .Mem_Cmd_Len(Mem_Cmd_Len),
    .Mem_Wr_Data(Mem_Wr_Data), .Line_Busy(Line_Busy), .Line_Done(Line_Done),
    .Underrun(Underrun)
  );

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [7:0]    len;
    logic [15:0]   data;
  } cmd_t;

  cmd_t exp_q[$];
  int   vec, miss, n_done, n_ack;
  logic saw_ack;

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  function automatic cmd_t mk_rd(int line, int b);
    cmd_t c;
    c.wr = 1'b0; c.addr = AW'(line * LP + b * BL); c.len = 8'd16; c.data = 16'd0;
    return c;
  endfunction

  function automatic cmd_t mk_wr(int addr, int data);
    cmd_t c;
    c.wr = 1'b1; c.addr = AW'(addr); c.len = 8'd1; c.data = 16'(data);
    return c;
  endfunction

  // Scoreboard side: inspects the cycle about to be clocked.
  task automatic observe();
    cmd_t got, want;
    saw_ack = Wr_Ack;
    if (Wr_Ack) n_ack++;
    if (Line_Done) n_done++;
    if (Wr_Ack || Line_Done) begin
      vec++;
      if (Wr_Ack && Line_Done) begin
        miss++; $display("FAIL ack_done_overlap: got both high, required at most one");
      end
    end
    if (Mem_Cmd_Valid && Mem_Cmd_Ready) begin
      got.wr = Mem_Cmd_Wr; got.addr = Mem_Cmd_Addr; got.len = Mem_Cmd_Len; got.data = Mem_Wr_Data;
      vec++;
      if (exp_q.size() == 0) begin
        miss++;
        $display("FAIL unexpected_cmd: got wr=%0d addr=%0d len=%0d, required no command",
                 got.wr, got.addr, got.len);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          miss++;
          $display("FAIL cmd: got wr=%0d addr=%0d len=%0d data=%h, required wr=%0d addr=%0d len=%0d data=%h",
                   got.wr, got.addr, got.len, got.data, want.wr, want.addr, want.len, want.data);
        end
      end
      if (Mem_Cmd_Wr) begin
        vec++;
        if (Wr_Ack !== 1'b1) begin
          miss++; $display("FAIL wr_ack: got %b on write transfer, required 1", Wr_Ack);
        end
      end
    end
  endtask

  task automatic tick();
    #1 observe();
    @(posedge vga_clk);
    @(negedge vga_clk);
  endtask

  task automatic test_reset();
    Line_Req_Sig = 1'b1; Wr_Req = 1'b1; Mem_Cmd_Ready = 1'b1;
    @(negedge vga_clk);
    #1;
    vec++;
    if ({Mem_Cmd_Valid, Wr_Ack, Line_Busy, Line_Done, Underrun, Mem_Cmd_Wr,
         Mem_Cmd_Addr, Mem_Cmd_Len, Mem_Wr_Data} !== '0) begin
      miss++; $display("FAIL reset_outputs: got valid=%b ack=%b busy=%b addr=%0d, required all 0",
                       Mem_Cmd_Valid, Wr_Ack, Line_Busy, Mem_Cmd_Addr);
    end
    Line_Req_Sig = 1'b0; Wr_Req = 1'b0;
    @(negedge vga_clk);
    rst_n = 1'b1;
    tick(); tick();
    vec++;
    if ({Mem_Cmd_Valid, Line_Busy} !== 2'b00) begin
      miss++; $display("FAIL reset_idle: got valid=%b busy=%b, required 0 0", Mem_Cmd_Valid, Line_Busy);
    end
  endtask

  task automatic test_line();
    int g = 0;
    n_done = 0;
    for (int b = 0; b < NB; b++) exp_q.push_back(mk_rd(2, b));
    Line_Num_Sig = 12'd2; Line_Req_Sig = 1'b1;
    tick();
    Line_Req_Sig = 1'b0;
    vec++;
    if (Line_Busy !== 1'b1) begin
      miss++; $display("FAIL line_busy_set: got %b, required 1", Line_Busy);
    end
    while (exp_q.size() > 0 && g < 1000) begin tick(); g++; end
    vec++;
    if (exp_q.size() != 0) begin
      miss++; $display("FAIL line_timeout: got %0d bursts left, required 0", exp_q.size());
      exp_q.delete();
    end
    vec++;
    if ({Line_Done, Line_Busy} !== 2'b10) begin
      miss++; $display("FAIL line_done: got done=%b busy=%b, required 1 0", Line_Done, Line_Busy);
    end
    tick();
    vec++;
    if (Line_Done !== 1'b0 || n_done != 1) begin
      miss++; $display("FAIL line_done_pulse: got done=%b count=%0d, required 0 1", Line_Done, n_done);
    end
  endtask

  task automatic test_stall();
    int g = 0;
    bit stalled = 1'b0;
    for (int b = 0; b < NB; b++) exp_q.push_back(mk_rd(7, b));
    Line_Num_Sig = 12'd7; Line_Req_Sig = 1'b1;
    tick();
    Line_Req_Sig = 1'b0;
    while (exp_q.size() > 0 && g < 1000) begin
      if (exp_q.size() == NB - 7 && !stalled) begin
        stalled = 1'b1;
        Mem_Cmd_Ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          tick(); g++;
          vec++;
          if ({Mem_Cmd_Valid, Mem_Cmd_Wr, Mem_Cmd_Addr, Mem_Cmd_Len} !==
              {1'b1, 1'b0, AW'(7 * LP + 7 * BL), 8'd16}) begin
            miss++; $display("FAIL stall_hold: got valid=%b addr=%0d len=%0d, required 1 %0d 16",
                             Mem_Cmd_Valid, Mem_Cmd_Addr, Mem_Cmd_Len, 7 * LP + 7 * BL);
          end
        end
        Mem_Cmd_Ready = 1'b1;
      end
      tick(); g++;
    end
    vec++;
    if (exp_q.size() != 0 || !stalled) begin
      miss++; $display("FAIL stall_timeout: got %0d left, required 0", exp_q.size());
      exp_q.delete();
    end
    tick();
  endtask

  task automatic test_interleave();
    int g = 0, w = 0;
    n_done = 0; n_ack = 0;
    for (int b = 0; b < NB; b++) begin
      exp_q.push_back(mk_rd(5, b));
      exp_q.push_back(mk_wr(100, 16'h4000 + b));
    end
    Line_Num_Sig = 12'd5; Line_Req_Sig = 1'b1;
    tick();
    Line_Req_Sig = 1'b0;
    Wr_Req = 1'b1; Wr_Addr = AW'(100); Wr_Data = 16'h4000;
    while (exp_q.size() > 0 && g < 2000) begin
      tick(); g++;
      if (saw_ack) begin
        w++;
        if (w == NB) Wr_Req = 1'b0;
        else Wr_Data = 16'(16'h4000 + w);
      end
    end
    Wr_Req = 1'b0;
    vec++;
    if (exp_q.size() != 0) begin
      miss++; $display("FAIL interleave_timeout: got %0d left, required 0", exp_q.size());
      exp_q.delete();
    end
    tick(); tick();
    vec++;
    if (n_ack != NB || n_done != 1) begin
      miss++; $display("FAIL interleave_counts: got acks=%0d done=%0d, required %0d 1", n_ack, n_done, NB);
    end
  endtask

  task automatic test_simultaneous();
    int g = 0;
    n_done = 0;
    exp_q.push_back(mk_rd(1, 0));
    exp_q.push_back(mk_wr(200, 16'h1234));
    for (int b = 1; b < NB; b++) exp_q.push_back(mk_rd(1, b));
    Line_Num_Sig = 12'd1; Line_Req_Sig = 1'b1;
    Wr_Req = 1'b1; Wr_Addr = AW'(200); Wr_Data = 16'h1234;
    tick();
    Line_Req_Sig = 1'b0;
    while (exp_q.size() > 0 && g < 1000) begin
      tick(); g++;
      if (saw_ack) Wr_Req = 1'b0;
    end
    vec++;
    if (exp_q.size() != 0) begin
      miss++; $display("FAIL simul_timeout: got %0d left, required 0", exp_q.size());
      exp_q.delete();
    end
    tick();
    vec++;
    if (n_done != 1) begin
      miss++; $display("FAIL simul_done: got %0d, required 1", n_done);
    end
  endtask

  task automatic test_underrun_reset();
    int g = 0;
    n_done = 0;
    vec++;
    if (Underrun !== 1'b0) begin
      miss++; $display("FAIL underrun_init: got %b, required 0", Underrun);
    end
    for (int b = 0; b < NB; b++) exp_q.push_back(mk_rd(3, b));
    Line_Num_Sig = 12'd3; Line_Req_Sig = 1'b1;
    tick();
    Line_Req_Sig = 1'b0;
    while (exp_q.size() > 0 && g < 1000) begin
      if (exp_q.size() == NB - 50) begin
        Line_Num_Sig = 12'd9; Line_Req_Sig = 1'b1;
        tick(); g++;
        Line_Req_Sig = 1'b0;
        vec++;
        if ({Underrun, Line_Busy} !== 2'b11) begin
          miss++; $display("FAIL underrun_set: got underrun=%b busy=%b, required 1 1", Underrun, Line_Busy);
        end
      end
      tick(); g++;
    end
    vec++;
    if (exp_q.size() != 0 || {Line_Done, Underrun} !== 2'b11) begin
      miss++; $display("FAIL underrun_finish: got left=%0d done=%b underrun=%b, required 0 1 1",
                       exp_q.size(), Line_Done, Underrun);
      exp_q.delete();
    end
    tick();
    // New line, reset once 80 bursts have gone.
    g = 0;
    for (int b = 0; b < 80; b++) exp_q.push_back(mk_rd(4, b));
    Line_Num_Sig = 12'd4; Line_Req_Sig = 1'b1;
    tick();
    Line_Req_Sig = 1'b0;
    while (exp_q.size() > 0 && g < 1000) begin tick(); g++; end
    rst_n = 1'b0;
    #1;
    vec++;
    if ({Mem_Cmd_Valid, Wr_Ack, Line_Busy, Line_Done, Underrun, Mem_Cmd_Wr,
         Mem_Cmd_Addr, Mem_Cmd_Len, Mem_Wr_Data} !== '0) begin
      miss++; $display("FAIL midline_reset: got valid=%b busy=%b underrun=%b addr=%0d, required all 0",
                       Mem_Cmd_Valid, Line_Busy, Underrun, Mem_Cmd_Addr);
    end
    @(negedge vga_clk);
    rst_n = 1'b1;
    for (int k = 0; k < 40; k++) tick();
    vec++;
    if ({Mem_Cmd_Valid, Line_Busy, Underrun} !== 3'b000) begin
      miss++; $display("FAIL post_reset_quiet: got valid=%b busy=%b underrun=%b, required 0 0 0",
                       Mem_Cmd_Valid, Line_Busy, Underrun);
    end
  endtask

  initial begin
    vec = 0; miss = 0; n_done = 0; n_ack = 0; saw_ack = 1'b0;
    rst_n = 1'b0; Line_Req_Sig = 1'b0; Line_Num_Sig = '0;
    Wr_Req = 1'b0; Wr_Addr = '0; Wr_Data = '0; Mem_Cmd_Ready = 1'b1;
    test_reset();
    test_line();
    test_stall();
    test_interleave();
    test_simultaneous();
    test_underrun_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule

// File: doc/vga_line_fetch_arbiter.md
VGA_LINE_FETCH_ARBITER -- requirements
Module: vga_line_fetch_arbiter

Interface
REQ-001 Parameter LINE_PIXELS, default 1920: pixels per active line; SHALL be an integer multiple of BURST_LEN.
REQ-002 Parameter BURST_LEN, default 16: pixels per read burst, range 1..255.
REQ-003 Parameter ADDR_W, default 22: memory word address width.
REQ-004 vga_clk  in  1  sole clock; all logic on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 Line_Req_Sig  in  1  one-cycle pulse requesting prefetch of one display line.
REQ-007 Line_Num_Sig  in  12  row index to fetch, sampled only when Line_Req_Sig=1.
REQ-008 Wr_Req  in  1  drawing-engine write request, level, held until Wr_Ack.
REQ-009 Wr_Addr  in  ADDR_W  write word address, stable while Wr_Req=1.
REQ-010 Wr_Data  in  16  write pixel, stable while Wr_Req=1.
REQ-011 Wr_Ack  out  1  one-cycle pulse: write command accepted by memory.
REQ-012 Mem_Cmd_Valid  out  1  command valid toward memory port.
REQ-013 Mem_Cmd_Ready  in  1  memory port accepts command.
REQ-014 Mem_Cmd_Wr  out  1  1=single write, 0=burst read.
REQ-015 Mem_Cmd_Addr  out  ADDR_W  command start address.
REQ-016 Mem_Cmd_Len  out  8  words in command: BURST_LEN for reads, 1 for writes.
REQ-017 Mem_Wr_Data  out  16  write data, valid with write command.
REQ-018 Line_Busy  out  1  line prefetch in progress.
REQ-019 Line_Done  out  1  one-cycle pulse: last burst of a line accepted.
REQ-020 Underrun  out  1  sticky: Line_Req_Sig arrived while a line was busy or pending.

Function
REQ-021 State machine SHALL have states IDLE, RD_ISSUE, WR_ISSUE; command transfers occur on cycles with Mem_Cmd_Valid=1 and Mem_Cmd_Ready=1.
REQ-022 While Mem_Cmd_Valid=1, Mem_Cmd_Wr/Addr/Len/Wr_Data SHALL stay constant until transfer; Mem_Cmd_Valid SHALL NOT drop before transfer.
REQ-023 Line_Req_Sig accepted in any state SHALL latch Line_Num_Sig, reset burst index to 0, and set Line_Busy on the next cycle.
REQ-024 Read address SHALL be Line_Num*LINE_PIXELS + burst_idx*BURST_LEN, computed at ADDR_W bits, truncated modulo 2^ADDR_W.
REQ-025 Bursts per line SHALL be LINE_PIXELS/BURST_LEN (120 at defaults); burst_idx increments on each read transfer.
REQ-026 IDLE: pending line -> RD_ISSUE; else Wr_Req=1 -> WR_ISSUE; pending line wins if both present in the same cycle.
REQ-027 RD_ISSUE transfer: if last burst -> Line_Done pulse next cycle, Line_Busy cleared that cycle, go WR_ISSUE if Wr_Req else IDLE; otherwise go WR_ISSUE if Wr_Req=1 else stay RD_ISSUE with next burst.
REQ-028 WR_ISSUE SHALL issue exactly one write (Len=1, Addr=Wr_Addr, Data=Wr_Data); on transfer pulse Wr_Ack the same cycle, then go RD_ISSUE if line busy else IDLE.
REQ-029 A write SHALL never be withdrawn by an arriving Line_Req_Sig; fetch resumes after its transfer, so at most one write interleaves between consecutive bursts.
REQ-030 Line_Req_Sig while Line_Busy=1: set Underrun, ignore request, current line continues unchanged.
REQ-031 Wr_Ack SHALL be 0 whenever Wr_Req=0; Line_Done and Wr_Ack are never high in the same cycle.

Reset
REQ-032 rst_n=0 SHALL immediately force state IDLE, burst index 0, and all outputs 0 (Mem_Cmd_Valid, Wr_Ack, Line_Busy, Line_Done, Underrun, Mem_Cmd_* fields).
REQ-033 Reset mid-line SHALL abandon the line; no further bursts issue after release until a new Line_Req_Sig.
REQ-034 Underrun SHALL clear only on reset.

Verification
REQ-035 Line_Req, Line_Num=2, Ready=1 always, no writes -> 120 reads, addresses 3840,3856,...,5744, Len=16, Line_Done pulse after 120th transfer.
REQ-036 Line fetch with Wr_Req held high, Wr_Addr=100 -> reads and writes alternate strictly; Wr_Ack per write; line still completes 120 bursts.
REQ-037 Mem_Cmd_Ready low 5 cycles during burst 7 -> command fields stable all 5 cycles, burst 7 issued once, no skip or duplicate.
REQ-038 Line_Req and Wr_Req same cycle in IDLE -> first command read burst 0; write follows immediately after its transfer.
REQ-039 Second Line_Req at burst 50 -> Underrun=1 stays set, line finishes original row; rst_n low at burst 80 -> all outputs 0, no commands after release.
